uart_frame_checker: RTL and testbench

Parametrised, sequential successor to the UART receive error checker. Consumes the serial bit stream one sampled bit at a time from the receive oversampler and rebuilds each frame: start bit, DATA_WIDTH data bits (LSB first), optional parity, STOP_BITS stop bits. Presents each frame as a registered data word with per-frame start/parity/stop error flags. Maintains sticky error status and saturating per-type error counters for the register block.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sat_counter.sv | 33 +++
 rtl/uart_frame_checker.sv | 181 ++++++++++++++++++
 tb/tb_uart_frame_checker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame checker: parity encodings, FSM state type and
// error-flag bit positions.
package uart_pkg;

  localparam logic [1:0] NOPARITY00 = 2'b00;
  localparam logic [1:0] ODD        = 2'b01;
  localparam logic [1:0] EVEN       = 2'b10;
  localparam logic [1:0] NOPARITY11 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned ERR_PARITY = 0;
  localparam int unsigned ERR_START  = 1;
  localparam int unsigned ERR_STOP   = 2;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == ODD) || (ptype == EVEN);
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module uart_sat_counter #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uart_frame_checker.sv
// Rebuilds UART frames from sampled line bits and reports per-frame and sticky errors.
// Define UART_ERR_COUNTERS_EN to add the three saturating per-type error counters.
module uart_frame_checker
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            parity_type,
  input  logic                  bit_valid,
  input  logic                  bit_value,
  input  logic                  frame_abort,
  input  logic                  clear_status,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [2:0]            error_flag,
  output logic [2:0]            sticky_status,
  output logic                  busy
`ifdef UART_ERR_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0]  parity_err_count,
  output logic [CNT_WIDTH-1:0]  start_err_count,
  output logic [CNT_WIDTH-1:0]  stop_err_count
`endif
);

  // One counter serves both the data-bit and stop-bit phases.
  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastDataBit = BitCntW'(DATA_WIDTH - 1);
  localparam logic [BitCntW-1:0] LastStopBit = BitCntW'(STOP_BITS - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      CNT_WIDTH == 0) begin : g_bad_params
    $error("uart_frame_checker: illegal parameter value");
  end

  uart_state_e           state_q, state_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            par_type_q, par_type_d;
  logic                  start_err_q, start_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  stop_err_q, stop_err_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic [2:0]            error_flag_q, error_flag_d;
  logic [2:0]            sticky_q, sticky_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_type_d   = par_type_q;
    start_err_d  = start_err_q;
    parity_err_d = parity_err_q;
    stop_err_d   = stop_err_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    error_flag_d = error_flag_q;

    if (frame_abort) begin
      state_d = StIdle;
    end else if (bit_valid) begin
      unique case (state_q)
        StIdle: begin
          start_err_d  = bit_value;
          parity_err_d = 1'b0;
          stop_err_d   = 1'b0;
          par_type_d   = parity_type;
          bit_cnt_d    = '0;
          state_d      = StData;
        end
        StData: begin
          shift_d   = {bit_value, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastDataBit) begin
            bit_cnt_d = '0;
            state_d   = parity_enabled(par_type_q) ? StParity : StStop;
          end
        end
        StParity: begin
          // Odd parity fails on an even total, even parity on an odd total.
          parity_err_d = ((^shift_q) ^ bit_value) == (par_type_q == EVEN);
          state_d      = StStop;
        end
        StStop: begin
          stop_err_d = stop_err_q | ~bit_value;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastStopBit) begin
            state_d                  = StIdle;
            data_valid_d             = 1'b1;
            data_out_d               = shift_q;
            error_flag_d[ERR_PARITY] = parity_err_q;
            error_flag_d[ERR_START]  = start_err_q;
            error_flag_d[ERR_STOP]   = stop_err_q | ~bit_value;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (clear_status) begin
      sticky_d = '0;
    end else if (data_valid_q) begin
      sticky_d = sticky_q | error_flag_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_type_q   <= NOPARITY00;
      start_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      error_flag_q <= '0;
      sticky_q     <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_type_q   <= par_type_d;
      start_err_q  <= start_err_d;
      parity_err_q <= parity_err_d;
      stop_err_q   <= stop_err_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      error_flag_q <= error_flag_d;
      sticky_q     <= sticky_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign error_flag    = error_flag_q;
  assign sticky_status = sticky_q;
  assign busy          = (state_q != StIdle);

`ifdef UART_ERR_COUNTERS_EN
  uart_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_parity_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (data_valid_q & error_flag_q[ERR_PARITY]),
    .clr  (clear_status),
    .count(parity_err_count)
  );

  uart_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_start_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (data_valid_q & error_flag_q[ERR_START]),
    .clr  (clear_status),
    .count(start_err_count)
  );

  uart_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stop_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (data_valid_q & error_flag_q[ERR_STOP]),
    .clr  (clear_status),
    .count(stop_err_count)
  );
`endif

endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed bench for uart_frame_checker: instance A (1 stop bit, 2-bit counters) and
// instance B (2 stop bits) share one stimulus stream and are checked in separate phases.
module tb_uart_frame_checker;
  import uart_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] parity_type;
  logic       bit_valid;
  logic       bit_value;
  logic       frame_abort;
  logic       clear_status;

  logic [7:0] a_data_out, b_data_out;
  logic       a_data_valid, b_data_valid;
  logic [2:0] a_error_flag, b_error_flag;
  logic [2:0] a_sticky, b_sticky;
  logic       a_busy, b_busy;
`ifdef UART_ERR_COUNTERS_EN
  logic [1:0] a_par_cnt, a_start_cnt, a_stop_cnt;
  logic [7:0] b_par_cnt, b_start_cnt, b_stop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int a_dv_cnt = 0;
  int dv_base;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (a_data_valid === 1'b1) a_dv_cnt <= a_dv_cnt + 1;
  end

  uart_frame_checker #(
    .DATA_WIDTH(8),
    .STOP_BITS (1),
    .CNT_WIDTH (2)
  ) dut_a (
    .clock           (clock),
    .reset           (reset),
    .parity_type     (parity_type),
    .bit_valid       (bit_valid),
    .bit_value       (bit_value),
    .frame_abort     (frame_abort),
    .clear_status    (clear_status),
    .data_out        (a_data_out),
    .data_valid      (a_data_valid),
    .error_flag      (a_error_flag),
    .sticky_status   (a_sticky),
    .busy            (a_busy)
`ifdef UART_ERR_COUNTERS_EN
    ,
    .parity_err_count(a_par_cnt),
    .start_err_count (a_start_cnt),
    .stop_err_count  (a_stop_cnt)
`endif
  );

  uart_frame_checker #(
    .DATA_WIDTH(8),
    .STOP_BITS (2),
    .CNT_WIDTH (8)
  ) dut_b (
    .clock           (clock),
    .reset           (reset),
    .parity_type     (parity_type),
    .bit_valid       (bit_valid),
    .bit_value       (bit_value),
    .frame_abort     (frame_abort),
    .clear_status    (clear_status),
    .data_out        (b_data_out),
    .data_valid      (b_data_valid),
    .error_flag      (b_error_flag),
    .sticky_status   (b_sticky),
    .busy            (b_busy)
`ifdef UART_ERR_COUNTERS_EN
    ,
    .parity_err_count(b_par_cnt),
    .start_err_count (b_start_cnt),
    .stop_err_count  (b_stop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic v);
    bit_valid = 1'b1;
    bit_value = v;
    @(posedge clock);
    #1;
    bit_valid = 1'b0;
    bit_value = 1'b1;
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic start, input logic [7:0] d, input logic has_par,
                            input logic par, input logic s0, input logic s1, input int nstop);
    send_bit(start);
    send_data(d);
    if (has_par) send_bit(par);
    send_bit(s0);
    if (nstop == 2) send_bit(s1);
  endtask

  initial begin
    reset        = 1'b1;
    parity_type  = EVEN;
    bit_valid    = 1'b0;
    bit_value    = 1'b1;
    frame_abort  = 1'b0;
    clear_status = 1'b0;
    tick(2);

    // Reset values
    check("rst_data_out", a_data_out, 8'h00);
    check("rst_data_valid", a_data_valid, 1'b0);
    check("rst_error_flag", a_error_flag, 3'b000);
    check("rst_sticky", a_sticky, 3'b000);
    check("rst_busy", a_busy, 1'b0);
`ifdef UART_ERR_COUNTERS_EN
    check("rst_par_cnt", a_par_cnt, 2'd0);
`endif
    reset = 1'b0;

    // Clean EVEN frame 0xA5, with latency check around the stop bit
    send_bit(1'b0);
    send_data(8'hA5);
    send_bit(1'b0);
    check("even_busy_mid", a_busy, 1'b1);
    check("even_dv_before_stop", a_data_valid, 1'b0);
    send_bit(1'b1);
    check("even_dv", a_data_valid, 1'b1);
    check("even_data", a_data_out, 8'hA5);
    check("even_flags", a_error_flag, 3'b000);
    tick(1);
    check("even_dv_pulse_end", a_data_valid, 1'b0);
    check("even_busy_idle", a_busy, 1'b0);
    check("even_data_hold", a_data_out, 8'hA5);

    // ODD parity error on 0x01 with parity bit 1
    parity_type = ODD;
    send_frame(1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    check("odd_perr_dv", a_data_valid, 1'b1);
    check("odd_perr_flags", a_error_flag, 3'b001);
    tick(1);
    check("odd_perr_sticky", a_sticky, 3'b001);

    // Start error + stop error, parity good
    send_frame(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    check("start_stop_flags", a_error_flag, 3'b110);
    check("start_stop_data", a_data_out, 8'h55);
    tick(1);
    check("start_stop_sticky", a_sticky, 3'b111);
`ifdef UART_ERR_COUNTERS_EN
    check("cnt_par_1", a_par_cnt, 2'd1);
    check("cnt_start_1", a_start_cnt, 2'd1);
    check("cnt_stop_1", a_stop_cnt, 2'd1);
`endif

    // clear_status alone
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    check("clear_sticky", a_sticky, 3'b000);
    check("clear_flags_kept", a_error_flag, 3'b110);
`ifdef UART_ERR_COUNTERS_EN
    check("clear_cnt_start", a_start_cnt, 2'd0);
`endif

    // Five back-to-back parity-error frames; clear coincident with the fifth data_valid
    for (int k = 0; k < 5; k++) begin
      send_frame(1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    end
    check("sat_dv", a_data_valid, 1'b1);
    check("sat_flags", a_error_flag, 3'b001);
`ifdef UART_ERR_COUNTERS_EN
    check("sat_par_cnt", a_par_cnt, 2'd3);
`endif
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    check("sat_clear_sticky", a_sticky, 3'b000);
    check("sat_clear_flags_kept", a_error_flag, 3'b001);
`ifdef UART_ERR_COUNTERS_EN
    check("sat_clear_par_cnt", a_par_cnt, 2'd0);
`endif

    // Abort after 4 data bits (coincident with a bit strobe), then a clean frame 0x3C
    parity_type = EVEN;
    dv_base = a_dv_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    frame_abort = 1'b1;
    bit_valid   = 1'b1;
    bit_value   = 1'b0;
    tick(1);
    frame_abort = 1'b0;
    bit_valid   = 1'b0;
    bit_value   = 1'b1;
    check("abort_busy", a_busy, 1'b0);
    check("abort_no_dv", a_data_valid, 1'b0);
    send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    check("abort_next_data", a_data_out, 8'h3C);
    check("abort_next_flags", a_error_flag, 3'b000);
    tick(1);
    check("abort_dv_count", a_dv_cnt - dv_base, 1);

    // Reset mid-frame
    dv_base = a_dv_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_data", a_data_out, 8'h00);
    check("midrst_flags", a_error_flag, 3'b000);
    check("midrst_sticky", a_sticky, 3'b000);
    tick(3);
    check("midrst_no_dv", a_dv_cnt - dv_base, 0);

    // parity_type flips EVEN->ODD mid-frame; then back-to-back ODD frame
    dv_base = a_dv_cnt;
    parity_type = EVEN;
    send_bit(1'b0);
    send_bit(1'b1);
    parity_type = ODD;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("latch_dv", a_data_valid, 1'b1);
    check("latch_data", a_data_out, 8'hA5);
    check("latch_flags", a_error_flag, 3'b000);
    send_frame(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    check("b2b_dv", a_data_valid, 1'b1);
    check("b2b_data", a_data_out, 8'h3C);
    check("b2b_flags", a_error_flag, 3'b000);
    tick(1);
    check("b2b_dv_count", a_dv_cnt - dv_base, 2);

    // Instance B: no parity, two stop bits, second stop bit low
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    parity_type = NOPARITY00;
    check("b_rst_flags", b_error_flag, 3'b000);
    send_bit(1'b0);
    send_data(8'h5A);
    send_bit(1'b1);
    check("b_busy_stop1", b_busy, 1'b1);
    check("b_dv_after_stop1", b_data_valid, 1'b0);
    send_bit(1'b0);
    check("b_dv", b_data_valid, 1'b1);
    check("b_data", b_data_out, 8'h5A);
    check("b_flags", b_error_flag, 3'b100);
    tick(1);
    check("b_sticky", b_sticky, 3'b100);
`ifdef UART_ERR_COUNTERS_EN
    check("b_stop_cnt", b_stop_cnt, 8'd1);
    check("b_par_cnt", b_par_cnt, 8'd0);
`endif
    parity_type = NOPARITY11;
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    check("b_np11_dv", b_data_valid, 1'b1);
    check("b_np11_data", b_data_out, 8'hC3);
    check("b_np11_flags", b_error_flag, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
